vector_sequencer: RTL and testbench

//   On-chip test-vector sequencer and checker. Stores {inputs, expected

---
 rtl/vector_sequencer_if.sv | 35 +++
 rtl/vector_sequencer.sv | 150 +++++++++++++++
 tb/tb_vector_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vector_sequencer_if.sv
// Port bundle for vector_sequencer: vector load, run control, DUT stimulus/response and result status.
interface vector_sequencer_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1,
    parameter int AW    = 4
);
    logic                  ld_en;
    logic [AW-1:0]         ld_addr;
    logic [IN_W+OUT_W-1:0] ld_data;
    logic [AW:0]           num_vec;
    logic                  start;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           err_count;
    logic [AW:0]           vec_idx;
    logic                  fail_vld;
    logic [AW:0]           fail_idx;
    logic [OUT_W-1:0]      fail_got;
    logic [OUT_W-1:0]      fail_exp;

    modport master (
        output ld_en, ld_addr, ld_data, num_vec, start, dut_out,
        input  dut_in, busy, done, pass, err_count, vec_idx,
               fail_vld, fail_idx, fail_got, fail_exp
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, num_vec, start, dut_out,
        output dut_in, busy, done, pass, err_count, vec_idx,
               fail_vld, fail_idx, fail_got, fail_exp
    );
endinterface

// File: rtl/vector_sequencer.sv
// On-chip test-vector sequencer: replays {stimulus, expected} vectors from a small RAM
// into a combinational DUT, counts mismatches and keeps the first failing vector.
module vector_sequencer #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int AW     = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vector_sequencer_if.slave    bus
);
    localparam int DEPTH = 1 << AW;
    localparam int WCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]    MAX_VEC  = (AW+1)'(DEPTH);
    localparam logic [WCW-1:0] WAIT_END = WCW'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
    typedef struct packed {
        logic [IN_W-1:0]  stim;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t mem [DEPTH];
    vec_t rd;

    state_t           state_q, state_d;
    logic [AW:0]      num_q, num_d, idx_q, idx_d, fidx_q, fidx_d;
    logic [IN_W-1:0]  din_q, din_d;
    logic [OUT_W-1:0] exp_q, exp_d, fgot_q, fgot_d, fexp_q, fexp_d;
    logic [15:0]      err_q, err_d, err_nxt;
    logic             fvld_q, fvld_d, pass_q, pass_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             idle_like, mism;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign mism      = (bus.dut_out != exp_q);
    assign rd        = mem[idx_q[AW-1:0]];

    // RAM is frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (reset && bus.ld_en && idle_like)
            mem[bus.ld_addr] <= bus.ld_data;
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        fidx_d  = fidx_q;
        din_d   = din_q;
        exp_d   = exp_q;
        fgot_d  = fgot_q;
        fexp_d  = fexp_q;
        err_d   = err_q;
        fvld_d  = fvld_q;
        pass_d  = pass_q;
        wcnt_d  = wcnt_q;
        err_nxt = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    num_d  = (bus.num_vec > MAX_VEC) ? MAX_VEC : bus.num_vec;
                    idx_d  = '0;
                    err_d  = '0;
                    fvld_d = 1'b0;
                    fidx_d = '0;
                    fgot_d = '0;
                    fexp_d = '0;
                    if (bus.num_vec == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = APPLY;
                        pass_d  = 1'b0;
                    end
                end
            end
            APPLY: begin
                din_d   = rd.stim;
                exp_d   = rd.exp;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == WAIT_END) state_d = CHECK;
                else                    wcnt_d  = wcnt_q + 1'b1;
            end
            CHECK: begin
                if (mism && err_q != 16'hFFFF) err_nxt = err_q + 16'd1;
                err_d = err_nxt;
                if (mism && !fvld_q) begin
                    fvld_d = 1'b1;
                    fidx_d = idx_q;
                    fgot_d = bus.dut_out;
                    fexp_d = exp_q;
                end
                if (idx_q == num_q - 1'b1) begin
                    state_d = DONE;
                    pass_d  = (err_nxt == '0);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            fidx_q  <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            fgot_q  <= '0;
            fexp_q  <= '0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            pass_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            fidx_q  <= fidx_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            fgot_q  <= fgot_d;
            fexp_q  <= fexp_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            pass_q  <= pass_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.dut_in    = din_q;
    assign bus.busy      = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = idx_q;
    assign bus.fail_vld  = fvld_q;
    assign bus.fail_idx  = fidx_q;
    assign bus.fail_got  = fgot_q;
    assign bus.fail_exp  = fexp_q;
endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer driving a y=(a&b)|c DUT; runs are described by table rows and
// their expected results go through a scoreboard queue that is drained when done rises.
module tb_vector_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vector_sequencer_if #(.IN_W(3), .OUT_W(1), .AW(4)) bus ();

    vector_sequencer #(.IN_W(3), .OUT_W(1), .AW(4), .SETTLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dut_out = (bus.dut_in[2] & bus.dut_in[1]) | bus.dut_in[0];

    typedef struct {
        int          nv;
        logic [15:0] mask;
        int          cyc;
        logic [15:0] err;
        logic        pass;
        logic        fvld;
        logic [4:0]  fidx;
        logic        got;
        logic        fexp;
        logic [4:0]  last_idx;
        logic [2:0]  last_din;
    } run_t;

    run_t tbl[8];
    run_t sb[$];

    function automatic logic gold(input int i);
        logic [2:0] v;
        v = i[2:0];
        return (v[2] & v[1]) | v[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = i[3:0];
            bus.ld_data = {i[2:0], gold(i) ^ mask[i]};
            step();
        end
        bus.ld_en = 1'b0;
    endtask

    task automatic run(input string tag, input run_t e, input bit inject);
        int   cyc;
        run_t r;
        sb.push_back(e);
        bus.num_vec = e.nv[4:0];
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 300) begin
            if (inject && cyc == 5) begin
                bus.start   = 1'b1;
                bus.num_vec = 5'd2;
                bus.ld_en   = 1'b1;
                bus.ld_addr = 4'd7;
                bus.ld_data = {3'b111, 1'b0};
            end
            step();
            bus.start = 1'b0;
            bus.ld_en = 1'b0;
            cyc++;
        end
        r = sb.pop_front();
        if (!bus.done) begin
            failures++;
            checks++;
            $display("FAIL %s timeout waiting for done", tag);
        end
        chk({tag, ".cycles"},   cyc,              r.cyc);
        chk({tag, ".busy"},     bus.busy,         0);
        chk({tag, ".err"},      bus.err_count,    r.err);
        chk({tag, ".pass"},     bus.pass,         r.pass);
        chk({tag, ".fail_vld"}, bus.fail_vld,     r.fvld);
        chk({tag, ".fail_idx"}, bus.fail_idx,     r.fidx);
        chk({tag, ".fail_got"}, bus.fail_got,     r.got);
        chk({tag, ".fail_exp"}, bus.fail_exp,     r.fexp);
        chk({tag, ".vec_idx"},  bus.vec_idx,      r.last_idx);
        chk({tag, ".dut_in"},   bus.dut_in,       r.last_din);
    endtask

    initial begin
        run_t clean;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.num_vec = '0;
        bus.start   = 1'b0;

        //        nv  mask      cyc err pass fvld fidx got fexp idx din
        tbl[0] = '{8,  16'h0000, 25, 0, 1, 0, 0,  0, 0, 7,  7};
        tbl[1] = '{8,  16'h0008, 25, 1, 0, 1, 3,  1, 0, 7,  7};
        tbl[2] = '{8,  16'h0024, 25, 2, 0, 1, 2,  0, 1, 7,  7};
        tbl[3] = '{4,  16'h0040, 13, 0, 1, 0, 0,  0, 0, 3,  3};
        tbl[4] = '{1,  16'h0001, 4,  1, 0, 1, 0,  0, 1, 0,  0};
        tbl[5] = '{20, 16'h0000, 49, 0, 1, 0, 0,  0, 0, 15, 7};
        tbl[6] = '{31, 16'h1000, 49, 1, 0, 1, 12, 0, 1, 15, 7};
        tbl[7] = '{16, 16'h8002, 49, 2, 0, 1, 1,  1, 0, 15, 7};

        repeat (3) step();
        chk("rst.busy",     bus.busy,      0);
        chk("rst.done",     bus.done,      0);
        chk("rst.pass",     bus.pass,      0);
        chk("rst.err",      bus.err_count, 0);
        chk("rst.dut_in",   bus.dut_in,    0);
        chk("rst.vec_idx",  bus.vec_idx,   0);
        chk("rst.fail_vld", bus.fail_vld,  0);
        reset = 1'b1;

        // Empty run straight out of reset: done/pass on the next cycle, no stimulus applied.
        load(16'h0000);
        bus.num_vec = 5'd0;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        chk("nv0.done",   bus.done,   1);
        chk("nv0.pass",   bus.pass,   1);
        chk("nv0.busy",   bus.busy,   0);
        chk("nv0.dut_in", bus.dut_in, 0);

        for (int t = 0; t < 8; t++) begin
            load(tbl[t].mask);
            run($sformatf("row%0d", t), tbl[t], 1'b0);
        end

        // Reset in the CHECK cycle of vector 4, with vector 1 already failed.
        load(16'h0002);
        bus.num_vec = 5'd8;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        chk("midrst.pre_busy", bus.busy,      1);
        chk("midrst.pre_idx",  bus.vec_idx,   4);
        chk("midrst.pre_err",  bus.err_count, 1);
        reset = 1'b0;
        step();
        chk("midrst.busy",     bus.busy,      0);
        chk("midrst.err",      bus.err_count, 0);
        chk("midrst.dut_in",   bus.dut_in,    0);
        chk("midrst.vec_idx",  bus.vec_idx,   0);
        chk("midrst.fail_vld", bus.fail_vld,  0);
        reset = 1'b1;
        run("rerun", '{8, 16'h0002, 25, 1, 0, 1, 1, 1, 0, 7, 7}, 1'b0);

        // start/ld_en pulsed mid-run must not disturb the run or the RAM.
        load(16'h0000);
        clean = tbl[0];
        run("busy_inject", clean, 1'b1);
        run("ram_intact", clean, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
